// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with integrated load-use hazard detection, branch-flush bubbles and stall freeze.
// Optional ID_EX_BUBBLE_COUNT_EN adds a saturating bubble counter output.
module id_ex_stage_reg #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [DATA_W-1:0] id_pc4,
  input  logic [DATA_W-1:0] id_rs_data,
  input  logic [DATA_W-1:0] id_rt_data,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic [REG_AW-1:0] id_rd,
  input  logic [5:0]        id_funct,
  input  logic [2:0]        id_alu_op,
  input  logic [6:0]        id_ctrl,
  input  logic              ex_flush,
  input  logic              ext_stall,
  output logic              ex_valid,
  output logic [DATA_W-1:0] ex_pc4,
  output logic [DATA_W-1:0] ex_rs_data,
  output logic [DATA_W-1:0] ex_rt_data,
  output logic [DATA_W-1:0] ex_imm,
  output logic [REG_AW-1:0] ex_rs,
  output logic [REG_AW-1:0] ex_rt,
  output logic [REG_AW-1:0] ex_rd,
  output logic [5:0]        ex_funct,
  output logic [2:0]        ex_alu_op,
  output logic [6:0]        ex_ctrl,
`ifdef ID_EX_BUBBLE_COUNT_EN
  output logic [31:0]       bubble_count,
`endif
  output logic              id_stall
);

  localparam int unsigned MEM_READ_BIT = 4;
  localparam int unsigned CNT_W        = 32;

  logic              valid_q,   valid_d;
  logic [DATA_W-1:0] pc4_q,     pc4_d;
  logic [DATA_W-1:0] rs_data_q, rs_data_d;
  logic [DATA_W-1:0] rt_data_q, rt_data_d;
  logic [DATA_W-1:0] imm_q,     imm_d;
  logic [REG_AW-1:0] rs_q,      rs_d;
  logic [REG_AW-1:0] rt_q,      rt_d;
  logic [REG_AW-1:0] rd_q,      rd_d;
  logic [5:0]        funct_q,   funct_d;
  logic [2:0]        alu_op_q,  alu_op_d;
  logic [6:0]        ctrl_q,    ctrl_d;

  logic hazard_c;
  logic bubble_load_c;

  // Load in EX whose destination is a source of the instruction in ID; $0 is exempt
  always_comb begin
    hazard_c = valid_q && ctrl_q[MEM_READ_BIT] && (rt_q != '0) && id_valid &&
               ((rt_q == id_rs) || (rt_q == id_rt));
  end

  // IF/ID is squashed by the same flush, so never hold it during one
  assign id_stall      = (hazard_c & ~ex_flush) | (ext_stall & ~ex_flush);
  assign bubble_load_c = ex_flush | (~ext_stall & hazard_c);

  always_comb begin
    valid_d   = valid_q;
    pc4_d     = pc4_q;
    rs_data_d = rs_data_q;
    rt_data_d = rt_data_q;
    imm_d     = imm_q;
    rs_d      = rs_q;
    rt_d      = rt_q;
    rd_d      = rd_q;
    funct_d   = funct_q;
    alu_op_d  = alu_op_q;
    ctrl_d    = ctrl_q;
    if (bubble_load_c) begin
      valid_d   = 1'b0;
      pc4_d     = '0;
      rs_data_d = '0;
      rt_data_d = '0;
      imm_d     = '0;
      rs_d      = '0;
      rt_d      = '0;
      rd_d      = '0;
      funct_d   = '0;
      alu_op_d  = '0;
      ctrl_d    = '0;
    end else if (!ext_stall) begin
      valid_d   = id_valid;
      pc4_d     = id_pc4;
      rs_data_d = id_rs_data;
      rt_data_d = id_rt_data;
      imm_d     = id_imm;
      rs_d      = id_rs;
      rt_d      = id_rt;
      rd_d      = id_rd;
      funct_d   = id_funct;
      alu_op_d  = id_alu_op;
      ctrl_d    = id_ctrl;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q   <= 1'b0;
      pc4_q     <= '0;
      rs_data_q <= '0;
      rt_data_q <= '0;
      imm_q     <= '0;
      rs_q      <= '0;
      rt_q      <= '0;
      rd_q      <= '0;
      funct_q   <= '0;
      alu_op_q  <= '0;
      ctrl_q    <= '0;
    end else begin
      valid_q   <= valid_d;
      pc4_q     <= pc4_d;
      rs_data_q <= rs_data_d;
      rt_data_q <= rt_data_d;
      imm_q     <= imm_d;
      rs_q      <= rs_d;
      rt_q      <= rt_d;
      rd_q      <= rd_d;
      funct_q   <= funct_d;
      alu_op_q  <= alu_op_d;
      ctrl_q    <= ctrl_d;
    end
  end

  assign ex_valid   = valid_q;
  assign ex_pc4     = pc4_q;
  assign ex_rs_data = rs_data_q;
  assign ex_rt_data = rt_data_q;
  assign ex_imm     = imm_q;
  assign ex_rs      = rs_q;
  assign ex_rt      = rt_q;
  assign ex_rd      = rd_q;
  assign ex_funct   = funct_q;
  assign ex_alu_op  = alu_op_q;
  assign ex_ctrl    = ctrl_q;

`ifdef ID_EX_BUBBLE_COUNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Saturating count of flush and load-use bubbles
  always_comb begin
    cnt_d = cnt_q;
    if (bubble_load_c && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign bubble_count = cnt_q;
`endif

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Scoreboard bench for id_ex_stage_reg: directed vectors push hand-computed EX state, a monitor compares each cycle.
module tb_id_ex_stage_reg;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc4;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] imm;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [5:0]  funct;
    logic [2:0]  alu_op;
    logic [6:0]  ctrl;
  } stage_t;

  typedef struct {
    int          step;
    stage_t      ex;
    logic        stall;
    logic [31:0] cnt;
  } exp_t;

  logic        clk, rst_n;
  logic        id_valid, ex_flush, ext_stall;
  logic [31:0] id_pc4, id_rs_data, id_rt_data, id_imm;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic [5:0]  id_funct;
  logic [2:0]  id_alu_op;
  logic [6:0]  id_ctrl;
  logic        ex_valid, id_stall;
  logic [31:0] ex_pc4, ex_rs_data, ex_rt_data, ex_imm;
  logic [4:0]  ex_rs, ex_rt, ex_rd;
  logic [5:0]  ex_funct;
  logic [2:0]  ex_alu_op;
  logic [6:0]  ex_ctrl;
`ifdef ID_EX_BUBBLE_COUNT_EN
  logic [31:0] bubble_count;
`endif

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   step_no = 0;

  id_ex_stage_reg dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid(id_valid), .id_pc4(id_pc4), .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
    .id_imm(id_imm), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_funct(id_funct),
    .id_alu_op(id_alu_op), .id_ctrl(id_ctrl), .ex_flush(ex_flush), .ext_stall(ext_stall),
    .ex_valid(ex_valid), .ex_pc4(ex_pc4), .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data),
    .ex_imm(ex_imm), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd), .ex_funct(ex_funct),
    .ex_alu_op(ex_alu_op), .ex_ctrl(ex_ctrl),
`ifdef ID_EX_BUBBLE_COUNT_EN
    .bubble_count(bubble_count),
`endif
    .id_stall(id_stall)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic stage_t mk(input logic v, input logic [31:0] pc4, input logic [31:0] rsd,
                                input logic [31:0] rtd, input logic [31:0] imm, input logic [4:0] rs,
                                input logic [4:0] rt, input logic [4:0] rd, input logic [5:0] f,
                                input logic [2:0] op, input logic [6:0] ctrl);
    stage_t s;
    s.valid = v; s.pc4 = pc4; s.rs_data = rsd; s.rt_data = rtd; s.imm = imm;
    s.rs = rs; s.rt = rt; s.rd = rd; s.funct = f; s.alu_op = op; s.ctrl = ctrl;
    return s;
  endfunction

  // One cycle: drive ID inputs just after the edge and record what EX must show mid-cycle
  task automatic step(input logic rst, input stage_t i, input logic fl, input logic st,
                      input stage_t e, input logic s, input logic [31:0] c);
    exp_t x;
    @(posedge clk);
    #1;
    rst_n = rst;
    id_valid = i.valid; id_pc4 = i.pc4; id_rs_data = i.rs_data; id_rt_data = i.rt_data;
    id_imm = i.imm; id_rs = i.rs; id_rt = i.rt; id_rd = i.rd; id_funct = i.funct;
    id_alu_op = i.alu_op; id_ctrl = i.ctrl; ex_flush = fl; ext_stall = st;
    x.step = step_no; x.ex = e; x.stall = s; x.cnt = c;
    sb.push_back(x);
    step_no++;
  endtask

  // Monitor: every mid-cycle sample is one presented output
  initial begin
    exp_t x;
    stage_t got;
    logic [31:0] got_cnt;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        x = sb.pop_front();
        got = mk(ex_valid, ex_pc4, ex_rs_data, ex_rt_data, ex_imm, ex_rs, ex_rt, ex_rd,
                 ex_funct, ex_alu_op, ex_ctrl);
`ifdef ID_EX_BUBBLE_COUNT_EN
        got_cnt = bubble_count;
`else
        got_cnt = x.cnt;
`endif
        n_cmp++;
        if (got !== x.ex || id_stall !== x.stall || got_cnt !== x.cnt) begin
          n_bad++;
          $display("FAIL step%0d: got ex=%h stall=%b cnt=%0d, required ex=%h stall=%b cnt=%0d",
                   x.step, got, id_stall, got_cnt, x.ex, x.stall, x.cnt);
        end
      end
    end
  end

  initial begin
    stage_t BUB, PT, LW8, ADD8, LW0, ADD0, INV, A1, A2, A3, LW2, ADDT;
    BUB  = '0;
    PT   = mk(1'b1, 32'h4,   32'h5,    32'h3,    32'h20, 5'd1,  5'd2,  5'd3,  6'h20, 3'b010, 7'b1000001);
    LW8  = mk(1'b1, 32'h104, 32'h1000, 32'h0,    32'h4,  5'd9,  5'd8,  5'd0,  6'h00, 3'b000, 7'b1110010);
    ADD8 = mk(1'b1, 32'h108, 32'h5,    32'h7,    32'h0,  5'd8,  5'd10, 5'd11, 6'h20, 3'b010, 7'b1000001);
    LW0  = mk(1'b1, 32'h204, 32'h2000, 32'h77,   32'h8,  5'd9,  5'd0,  5'd0,  6'h00, 3'b000, 7'b1110010);
    ADD0 = mk(1'b1, 32'h208, 32'h0,    32'h9,    32'h0,  5'd0,  5'd12, 5'd13, 6'h22, 3'b010, 7'b1000001);
    INV  = mk(1'b0, 32'h30c, 32'hAAAA, 32'hBBBB, 32'h10, 5'd3,  5'd4,  5'd5,  6'h25, 3'b010, 7'b1000001);
    A1   = mk(1'b1, 32'h400, 32'h1,    32'h1,    32'h1,  5'd14, 5'd15, 5'd16, 6'h24, 3'b010, 7'b1000001);
    A2   = mk(1'b1, 32'h404, 32'h2,    32'h2,    32'h2,  5'd14, 5'd15, 5'd16, 6'h25, 3'b010, 7'b1000001);
    A3   = mk(1'b1, 32'h408, 32'h3,    32'h3,    32'h3,  5'd17, 5'd18, 5'd19, 6'h2a, 3'b010, 7'b1000001);
    LW2  = mk(1'b1, 32'h50c, 32'h3000, 32'h0,    32'hc,  5'd8,  5'd10, 5'd0,  6'h00, 3'b000, 7'b1110010);
    ADDT = mk(1'b1, 32'h510, 32'h1,    32'h2,    32'h0,  5'd1,  5'd10, 5'd20, 6'h21, 3'b010, 7'b1000001);

    rst_n = 1'b0;
    id_valid = 1'b0; id_pc4 = '0; id_rs_data = '0; id_rt_data = '0; id_imm = '0;
    id_rs = '0; id_rt = '0; id_rd = '0; id_funct = '0; id_alu_op = '0; id_ctrl = '0;
    ex_flush = 1'b0; ext_stall = 1'b0;

    //   rst   ID     fl    st    expected EX  stall  count
    step(1'b0, PT,   1'b0, 1'b0, BUB,  1'b0, 32'd0);   // reset state
    step(1'b1, PT,   1'b0, 1'b0, BUB,  1'b0, 32'd0);
    step(1'b1, LW8,  1'b0, 1'b0, PT,   1'b0, 32'd0);   // pass-through
    step(1'b1, ADD8, 1'b0, 1'b0, LW8,  1'b1, 32'd0);   // load-use on rs
    step(1'b1, ADD8, 1'b0, 1'b0, BUB,  1'b0, 32'd1);   // single bubble
    step(1'b1, LW0,  1'b0, 1'b0, ADD8, 1'b0, 32'd1);
    step(1'b1, ADD0, 1'b0, 1'b0, LW0,  1'b0, 32'd1);   // $0 exemption
    step(1'b1, INV,  1'b0, 1'b0, ADD0, 1'b0, 32'd1);
    step(1'b1, A1,   1'b0, 1'b1, INV,  1'b1, 32'd1);   // invalid copied, freeze begins
    step(1'b1, A2,   1'b0, 1'b1, INV,  1'b1, 32'd1);
    step(1'b1, A3,   1'b0, 1'b1, INV,  1'b1, 32'd1);
    step(1'b1, A3,   1'b0, 1'b0, INV,  1'b0, 32'd1);
    step(1'b1, LW8,  1'b0, 1'b0, A3,   1'b0, 32'd1);   // loads current ID after freeze
    step(1'b1, ADD8, 1'b1, 1'b1, LW8,  1'b0, 32'd1);   // flush beats stall and hazard
    step(1'b1, PT,   1'b0, 1'b0, BUB,  1'b0, 32'd2);
    step(1'b1, LW8,  1'b0, 1'b0, PT,   1'b0, 32'd2);
    step(1'b1, LW2,  1'b0, 1'b0, LW8,  1'b1, 32'd2);   // back-to-back dependent loads
    step(1'b1, LW2,  1'b0, 1'b0, BUB,  1'b0, 32'd3);
    step(1'b1, ADDT, 1'b0, 1'b0, LW2,  1'b1, 32'd3);   // load-use on rt
    step(1'b1, ADDT, 1'b0, 1'b0, BUB,  1'b0, 32'd4);
    step(1'b1, PT,   1'b0, 1'b0, ADDT, 1'b0, 32'd4);
    step(1'b1, LW8,  1'b0, 1'b0, BUB,  1'b0, 32'd0);   // async reset mid-cycle
    #2 rst_n = 1'b0;
    step(1'b0, PT,   1'b0, 1'b0, BUB,  1'b0, 32'd0);
    step(1'b1, ADD8, 1'b0, 1'b0, BUB,  1'b0, 32'd0);
    step(1'b1, BUB,  1'b0, 1'b0, ADD8, 1'b0, 32'd0);   // first edge after release loads
    step(1'b1, BUB,  1'b0, 1'b0, BUB,  1'b0, 32'd0);

    repeat (2) @(posedge clk);
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations left, required 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/id_ex_stage_reg.md
Name: id_ex_stage_reg

Overview:
- ID/EX pipeline register of the 5-stage MIPS core, with integrated load-use hazard detection.
- Captures decoded operands and control from ID each cycle and presents them to EX.
- Its ex_funct and ex_alu_op outputs drive the ALU control unit directly.
- Inserts bubbles on load-use hazards and branch flushes; freezes on downstream stall.

Parameters:
DATA_W, 32, operand/PC/immediate width
REG_AW, 5, register-address width

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  async active-low reset
id_valid  in  1  ID holds a real instruction
id_pc4  in  DATA_W  PC+4 of ID instruction
id_rs_data  in  DATA_W  register-file read port A
id_rt_data  in  DATA_W  register-file read port B
id_imm  in  DATA_W  sign-extended immediate
id_rs  in  REG_AW  rs field
id_rt  in  REG_AW  rt field
id_rd  in  REG_AW  rd field
id_funct  in  6  instr[5:0]
id_alu_op  in  3  ALU-op class from main control
id_ctrl  in  7  {reg_write, mem_to_reg, mem_read, mem_write, branch, alu_src, reg_dst}
ex_flush  in  1  branch taken in EX; squash ID instruction
ext_stall  in  1  downstream freeze (memory wait)
ex_valid  out  1  EX instruction is real
ex_pc4, ex_rs_data, ex_rt_data, ex_imm  out  DATA_W each  registered copies
ex_rs, ex_rt, ex_rd  out  REG_AW each  registered copies
ex_funct  out  6  to ALU control
ex_alu_op  out  3  to ALU control
ex_ctrl  out  7  registered id_ctrl
id_stall  out  1  hold PC and IF/ID; combinational

Behaviour:
- Reset: rst_n low asynchronously forces every registered output to 0, giving a bubble. ex_valid=0, ex_ctrl=0, ex_alu_op=0, ex_funct=0, all data/address fields 0. Release is synchronous to the next clk edge.
- Bubble: ex_valid=0, ex_ctrl=0, ex_alu_op=0, ex_funct=0, data and address fields 0. A bubble writes nothing and accesses no memory.
- Load-use hazard (combinational) requires all of:
  - ex_valid=1
  - ex_ctrl mem_read bit=1
  - ex_rt!=0
  - id_valid=1
  - ex_rt==id_rs or ex_rt==id_rt
- Rising-edge update, priority high to low:
  1. ex_flush=1: load bubble. Hazard ignored. Flush wins even when ext_stall=1.
  2. ext_stall=1: hold all registers unchanged.
  3. hazard=1: load bubble. ID instruction stays in IF/ID for the next cycle.
  4. Otherwise: load all id_* fields. ex_valid<=id_valid.
  - id_valid=0 on a normal load yields ex_valid=0 with other fields copied. Downstream qualifies its side effects by ex_valid.
- id_stall = (hazard & ~ex_flush) | (ext_stall & ~ex_flush). It is never asserted during flush, because IF/ID is squashed by the same flush.
- Latency: 1 cycle ID to EX.
- Load-use penalty: exactly 1 bubble. After the bubble, the load sits in MEM and the hazard term is 0, so the dependent instruction advances; MEM/WB forwarding is owned by the forwarding unit.
- Back-to-back loads with a dependency: each pair handled independently, one bubble per dependent consumer.
- Register $0 never triggers a hazard.
- No arithmetic is performed; all widths pass through unchanged.

Optional Feature:
- Macro: ID_EX_BUBBLE_COUNT_EN.
- Defined:
  - Adds output bubble_count [31:0].
  - Increments by 1 on each edge where a bubble is loaded by rule 1 or rule 3.
  - Saturates at 32'hFFFF_FFFF.
  - Cleared by rst_n.
  - Holds during ext_stall.
- Undefined: port and logic absent; all other behaviour identical.

Test Plan:
- Pass-through: id_valid=1, id_funct=6'h20, id_alu_op=3'b010, id_rs_data=32'h5 -> next edge ex_funct=6'h20, ex_alu_op=3'b010, ex_rs_data=32'h5, ex_valid=1, id_stall=0.
- Load-use: EX holds lw with mem_read=1, ex_rt=8; ID holds add with id_rs=8 -> id_stall=1 same cycle; next edge ex_valid=0, ex_ctrl=0; following edge add loaded, id_stall=0.
- $0 exemption: EX lw with ex_rt=0, ID id_rs=0 -> id_stall=0, no bubble.
- Freeze: ext_stall=1 for 3 cycles while id_* changes -> all ex_* outputs constant, id_stall=1; ext_stall=0 -> loads current id_*.
- Flush priority: load-use hazard, ext_stall=1 and ex_flush=1 in the same cycle -> next edge bubble, id_stall=0; with ID_EX_BUBBLE_COUNT_EN defined, bubble_count increments by exactly 1.
- Reset mid-operation: rst_n low between edges with ex_valid=1 -> outputs zero immediately, without waiting for clk; first edge after release loads id_* normally.
